seg_disp_scanner: RTL and testbench

Multiplexed display scanner that sits directly upstream of `bcd_to_seg_disp`. It accepts a multi-digit packed BCD word through a valid/ready handshake and time-multiplexes one digit at a time onto a 4-bit BCD bus. It drives active-low digit selects, with a dead-time blank between digits to suppress ghosting. Display updates are tear-free: new data is committed only at frame boundaries.

---
 rtl/seg_disp_pkg.sv | 15 +
 rtl/seg_disp_slot_timer.sv | 59 +++++
 rtl/seg_disp_scanner.sv | 133 +++++++++++++
 tb/tb_seg_disp_scanner.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_disp_pkg.sv
// Shared types and helpers for the multiplexed seven-segment scanner.
package seg_disp_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic bcd_nibble_ok(input logic [3:0] nib);
        return nib <= BCD_MAX;
    endfunction

endpackage

// File: rtl/seg_disp_slot_timer.sv
// Slot/frame timebase: cnt walks each digit slot (dead-time then show), idx walks the digits.
module seg_disp_slot_timer
    import seg_disp_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 16,
    parameter int IW           = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [IW-1:0] idx,
    output logic          slot_start,
    output logic          show_phase,
    output logic          frame_end
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    scan_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BLANK;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        if (cnt_q == CNT_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end else if (cnt_q == BLANK_END) begin
            state_d = SHOW;
        end
    end

    always_comb begin
        idx        = idx_q;
        slot_start = (cnt_q == '0);
        show_phase = (state_q == SHOW);
        frame_end  = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);
    end

endmodule

// File: rtl/seg_disp_scanner.sv
// Multiplexed BCD display scanner: buffered load handshake, frame-boundary commit,
// leading-zero / invalid-digit blanking and registered digit-select outputs.
module seg_disp_scanner
    import seg_disp_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    lz_blank_en,
    output logic [3:0]              bcd_out,
    output logic                    dp_out,
    output logic                    blank,
    output logic [NUM_DIGITS-1:0]   digit_sel_n,
    output logic                    frame_done,
    output logic                    bcd_err
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [NUM_DIGITS-1:0] SEL_ONE = NUM_DIGITS'(1);

    logic [IW-1:0] idx;
    logic          slot_start, show_phase, frame_end;

    seg_disp_slot_timer #(
        .NUM_DIGITS  (NUM_DIGITS),
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYCLES(BLANK_CYCLES),
        .IW          (IW)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .idx       (idx),
        .slot_start(slot_start),
        .show_phase(show_phase),
        .frame_end (frame_end)
    );

    logic [4*NUM_DIGITS-1:0] disp_q, disp_d, pend_q, pend_d;
    logic                    pend_valid_q, pend_valid_d;
    logic [NUM_DIGITS-1:0]   dp_lat_q, dp_lat_d;
    logic                    lz_lat_q, lz_lat_d;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;
    logic [3:0]              bcd_q, bcd_d;
    logic                    dp_q, dp_d, blank_q, blank_d, fd_q, fd_d, err_q, err_d;

    logic                  accept, load_bad, zero_run, shown;
    logic [NUM_DIGITS-1:0] dig_blank;

    assign accept = load_valid && !pend_valid_q;

    // zero_run tracks "every nibble from the top down to i is zero" for leading-zero blanking
    always_comb begin
        dig_blank = '0;
        zero_run  = 1'b1;
        load_bad  = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run     = zero_run && (disp_q[4*i +: 4] == 4'd0);
            dig_blank[i] = !bcd_nibble_ok(disp_q[4*i +: 4]) || (lz_lat_q && (i > 0) && zero_run);
            if (!bcd_nibble_ok(load_data[4*i +: 4])) begin
                load_bad = 1'b1;
            end
        end
    end

    always_comb begin
        disp_d       = disp_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        if (frame_end && pend_valid_q) begin
            disp_d       = pend_q;
            pend_valid_d = 1'b0;
        end else if (accept) begin
            pend_d       = load_data;
            pend_valid_d = 1'b1;
        end
        dp_lat_d = slot_start ? dp_mask : dp_lat_q;
        lz_lat_d = slot_start ? lz_blank_en : lz_lat_q;
    end

    always_comb begin
        shown   = show_phase && !dig_blank[idx];
        sel_d   = shown ? ~(SEL_ONE << idx) : '1;
        bcd_d   = disp_q[{idx, 2'b00} +: 4];
        dp_d    = shown && dp_lat_q[idx];
        blank_d = !shown;
        fd_d    = frame_end;
        err_d   = accept && load_bad;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q       <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            dp_lat_q     <= '0;
            lz_lat_q     <= 1'b0;
            sel_q        <= '1;
            bcd_q        <= '0;
            dp_q         <= 1'b0;
            blank_q      <= 1'b1;
            fd_q         <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            dp_lat_q     <= dp_lat_d;
            lz_lat_q     <= lz_lat_d;
            sel_q        <= sel_d;
            bcd_q        <= bcd_d;
            dp_q         <= dp_d;
            blank_q      <= blank_d;
            fd_q         <= fd_d;
            err_q        <= err_d;
        end
    end

    assign load_ready  = !pend_valid_q;
    assign digit_sel_n = sel_q;
    assign bcd_out     = bcd_q;
    assign dp_out      = dp_q;
    assign blank       = blank_q;
    assign frame_done  = fd_q;
    assign bcd_err     = err_q;

endmodule

// File: tb/tb_seg_disp_scanner.sv
// Bench for seg_disp_scanner: frame-position reference model checked every cycle,
// plus directed loads with hand-computed literal expectations.
module tb_seg_disp_scanner;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BC = 2;
    localparam int FR = ND * RD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [15:0] load_data = '0;
    logic [3:0]  dp_mask = 4'b0101;
    logic        lz_blank_en = 1'b0;
    logic [3:0]  bcd_out;
    logic        dp_out, blank, frame_done, bcd_err;
    logic [3:0]  digit_sel_n;

    seg_disp_scanner #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .dp_mask    (dp_mask),
        .lz_blank_en(lz_blank_en),
        .bcd_out    (bcd_out),
        .dp_out     (dp_out),
        .blank      (blank),
        .digit_sel_n(digit_sel_n),
        .frame_done (frame_done),
        .bcd_err    (bcd_err)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int e      = 0;
    bit cmp_en = 0;

    // Reference model: position in the frame decides everything
    int          t = 0;
    logic [15:0] m_disp = '0, m_pend = '0;
    bit          m_pv = 0, m_lz = 0;
    logic [3:0]  m_dp = '0;
    logic [3:0]  x_sel = 4'hF, x_bcd = '0;
    bit          x_dp = 0, x_blank = 1, x_fd = 0, x_err = 0;

    function automatic bit is_blanked(input logic [15:0] d, input int i, input bit lz);
        logic [15:0] upper;
        upper = d >> (4 * i);
        return ((upper & 16'hF) > 9) || (lz && (i > 0) && (upper == 0));
    endfunction

    function automatic bit has_bad(input logic [15:0] d);
        for (int i = 0; i < ND; i++) begin
            if (((d >> (4 * i)) & 16'hF) > 9) return 1'b1;
        end
        return 1'b0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int p, di, c;
        bit shown, acc;
        if (!rst_n) begin
            t = 0; m_disp = '0; m_pend = '0; m_pv = 0; m_dp = '0; m_lz = 0;
            x_sel = 4'hF; x_bcd = '0; x_dp = 0; x_blank = 1; x_fd = 0; x_err = 0;
        end else begin
            p  = t % FR;
            di = p / RD;
            c  = p % RD;
            shown   = (c >= BC) && !is_blanked(m_disp, di, m_lz);
            x_sel   = shown ? (4'hF & ~(4'b0001 << di)) : 4'hF;
            x_bcd   = 4'((m_disp >> (4 * di)) & 16'hF);
            x_dp    = shown && m_dp[di];
            x_blank = !shown;
            x_fd    = (p == FR - 1);
            acc     = load_valid && !m_pv;
            x_err   = acc && has_bad(load_data);
            if (p == FR - 1 && m_pv) begin
                m_disp = m_pend;
                m_pv   = 0;
            end else if (acc) begin
                m_pend = load_data;
                m_pv   = 1;
            end
            if (c == 0) begin
                m_dp = dp_mask;
                m_lz = lz_blank_en;
            end
            t++;
        end
    end

    always @(negedge clk) begin
        logic [11:0] act, req;
        if (cmp_en) begin
            act = {digit_sel_n, bcd_out, dp_out, blank, frame_done, bcd_err, load_ready};
            req = {x_sel, x_bcd, x_dp, x_blank, x_fd, x_err, !m_pv};
            n_vec++;
            if (act !== req) begin
                n_miss++;
                $display("FAIL model t=%0d: got sel/bcd/dp/blank/fd/err/rdy=%b expected %b", t, act, req);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic tick_to(input int target);
        while (e < target) tick();
    endtask

    task automatic load(input logic [15:0] d);
        load_valid = 1'b1;
        load_data  = d;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic find_digit0(input logic [3:0] v, output int at);
        at = -1;
        for (int k = 0; k < 3 * FR && at < 0; k++) begin
            tick();
            if (bcd_out == v && digit_sel_n == 4'b1110) at = e;
        end
    endtask

    initial begin
        int fd_edge, sel0_cnt, vis;
        repeat (2) @(posedge clk);
        cmp_en = 1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        e = 0;
        $display("reset released");
        chk("reset_sel", digit_sel_n, 4'hF);
        chk("reset_blank", blank, 1);
        chk("reset_ready", load_ready, 1);

        // Free-running first frame
        fd_edge = -1;
        sel0_cnt = 0;
        while (e < FR) begin
            tick();
            if (frame_done && fd_edge < 0) fd_edge = e;
            if (digit_sel_n == 4'b1110) sel0_cnt++;
        end
        chk("frame_done_cycle", fd_edge - 1, 31);
        chk("digit0_low_cycles", sel0_cnt, 6);
        $display("frame 0 scanned");

        // Load 1234, then a refused 5678
        load(16'h1234);
        chk("ready_after_load", load_ready, 0);
        load(16'h5678);
        $display("loaded 1234, attempted 5678");
        tick_to(63);
        chk("ready_before_commit", load_ready, 0);
        tick();
        chk("ready_after_commit", load_ready, 1);
        tick_to(68);
        chk("d0_bcd", bcd_out, 4);
        chk("d0_sel", digit_sel_n, 4'b1110);
        chk("d0_dp", dp_out, 1);
        tick_to(76);
        chk("d1_bcd", bcd_out, 3);
        chk("d1_sel", digit_sel_n, 4'b1101);
        tick_to(84);
        chk("d2_bcd", bcd_out, 2);
        tick_to(92);
        chk("d3_bcd", bcd_out, 1);
        chk("d3_sel", digit_sel_n, 4'b0111);

        // Load one cycle before vs on the frame-end cycle
        tick_to(94);
        load(16'h0007);
        find_digit0(4'h7, vis);
        chk("early_load_visible", vis, 99);
        $display("load at 94 visible at edge %0d", vis);
        tick_to(127);
        load(16'h0008);
        chk("frame_end_load_pending", load_ready, 0);
        find_digit0(4'h8, vis);
        chk("frame_end_load_visible", vis, 163);
        $display("load at 127 visible at edge %0d", vis);

        // Leading-zero blanking
        tick_to(165);
        lz_blank_en = 1'b1;
        load(16'h0050);
        tick_to(196);
        chk("lz_d0_sel", digit_sel_n, 4'b1110);
        chk("lz_d0_bcd", bcd_out, 0);
        tick_to(204);
        chk("lz_d1_sel", digit_sel_n, 4'b1101);
        chk("lz_d1_bcd", bcd_out, 5);
        tick_to(212);
        chk("lz_d2_blank", blank, 1);
        chk("lz_d2_sel", digit_sel_n, 4'hF);
        tick_to(220);
        chk("lz_d3_blank", blank, 1);
        tick_to(224);
        lz_blank_en = 1'b0;
        tick_to(244);
        chk("nolz_d2_sel", digit_sel_n, 4'b1011);
        tick_to(252);
        chk("nolz_d3_sel", digit_sel_n, 4'b0111);
        chk("nolz_d3_blank", blank, 0);
        $display("0050 scanned with and without lz blanking");

        // Invalid nibble
        load(16'h12A4);
        chk("bcd_err_pulse", bcd_err, 1);
        tick();
        chk("bcd_err_single", bcd_err, 0);
        tick_to(260);
        chk("err_d0_bcd", bcd_out, 4);
        tick_to(268);
        chk("err_d1_sel", digit_sel_n, 4'hF);
        chk("err_d1_bcd", bcd_out, 4'hA);
        tick_to(276);
        chk("err_d2_sel", digit_sel_n, 4'b1011);
        tick_to(300);
        chk("err_d1_next_blank", blank, 1);
        $display("12A4 scanned");

        // Reset mid-SHOW with a pending load
        load(16'h9999);
        chk("pend_before_reset", load_ready, 0);
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst_sel", digit_sel_n, 4'hF);
        chk("rst_blank", blank, 1);
        chk("rst_bcd", bcd_out, 0);
        chk("rst_ready", load_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        e = 0;
        tick_to(4);
        chk("post_rst_d0_sel", digit_sel_n, 4'b1110);
        chk("post_rst_d0_bcd", bcd_out, 0);
        tick_to(32);
        chk("post_rst_fd", frame_done, 1);
        tick_to(36);
        chk("pend_discarded", bcd_out, 0);
        $display("reset mid-frame handled");

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
